// File: rtl/multichannel_chunk_processor.sv
// Multichannel chunk processor.
// Walks IO_BUFF_SIZE x NUM_CH interleaved samples (sample-major, channel-minor)
// from a sync-read input buffer, through an external nd/rfd/rdy streaming filter
// (or straight across in bypass), and into the output buffer.
//
// Read-address timing: the input buffer returns data one cycle after the
// address is presented. The read address for sample k+1 is therefore advanced
// on the edge that leaves FETCH for sample k, so the data is already waiting
// when the next FETCH is reached. The read address rests at (0,0) in IDLE, so
// the first sample of a chunk is ready whether or not a start delay is used.
// out_ptr/out_ch are latched from the read address as it leaves FETCH, so the
// write side carries the same ptr/ch as the read side for each sample.
module multichannel_chunk_processor #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
  parameter int NUM_CH           = 2,
  parameter int CH_BITS          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int FILT_OUT_SIZE    = 40,
  parameter int FILT_SHIFT       = 15,
  parameter int START_DELAY      = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               chunk_pulse,
  input  logic                               bypass,
  output logic [IO_BUFF_PTR_BITS-1:0]        in_ptr,
  output logic [CH_BITS-1:0]                 in_ch,
  input  logic signed [SAMPLE_SIZE-1:0]      in_sample,
  output logic signed [SAMPLE_SIZE-1:0]      flt_din,
  output logic                               flt_nd,
  input  logic                               flt_rfd,
  input  logic                               flt_rdy,
  input  logic signed [FILT_OUT_SIZE-1:0]    flt_dout,
  output logic [IO_BUFF_PTR_BITS-1:0]        out_ptr,
  output logic [CH_BITS-1:0]                 out_ch,
  output logic signed [SAMPLE_SIZE-1:0]      out_sample,
  output logic                               out_we,
  output logic                               busy,
  output logic                               done,
  output logic                               overrun
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DELAY    = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] WAIT_RFD = 3'd3;
  localparam logic [2:0] WAIT_RDY = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;

  localparam int DLY_BITS = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_BITS-1:0]         DLY_LAST = DLY_BITS'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
  localparam logic [CH_BITS-1:0]          CH_LAST  = CH_BITS'(NUM_CH - 1);

  // Clamp limits of the output sample, expressed at filter-result width.
  localparam logic signed [FILT_OUT_SIZE-1:0] SAT_MAX =
    {{(FILT_OUT_SIZE-SAMPLE_SIZE+1){1'b0}}, {(SAMPLE_SIZE-1){1'b1}}};
  localparam logic signed [FILT_OUT_SIZE-1:0] SAT_MIN =
    {{(FILT_OUT_SIZE-SAMPLE_SIZE+1){1'b1}}, {(SAMPLE_SIZE-1){1'b0}}};

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [DLY_BITS-1:0] dly_cnt;
  logic                bypass_l;
  logic                last_wr;

  // Arithmetic right shift of the wide filter result, then saturate to the sample range.
  function automatic logic signed [SAMPLE_SIZE-1:0] sat_scale(input logic signed [FILT_OUT_SIZE-1:0] d);
    logic signed [FILT_OUT_SIZE-1:0] shifted;
    shifted = d >>> FILT_SHIFT;
    if (shifted > SAT_MAX)
      return SAT_MAX[SAMPLE_SIZE-1:0];
    else if (shifted < SAT_MIN)
      return SAT_MIN[SAMPLE_SIZE-1:0];
    else
      return shifted[SAMPLE_SIZE-1:0];
  endfunction

  assign last_wr = (out_ptr == PTR_LAST) && (out_ch == CH_LAST);
  assign out_we  = (state == WRITE);
  assign busy    = (state != IDLE);

  // Next-state decode; nd is issued in the very cycle rfd is seen, and leaving
  // WAIT_RFD on that same edge guarantees a single nd per sample.
  always_comb begin
    state_nxt = state;
    flt_nd    = 1'b0;
    case (state)
      IDLE:     if (chunk_pulse) state_nxt = (START_DELAY == 0) ? FETCH : DELAY;
      DELAY:    if (dly_cnt == DLY_LAST) state_nxt = FETCH;
      FETCH:    state_nxt = bypass_l ? WRITE : WAIT_RFD;
      WAIT_RFD: begin
        if (flt_rfd) begin
          flt_nd    = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: if (flt_rdy) state_nxt = WRITE;
      WRITE:    state_nxt = last_wr ? IDLE : FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any chunk in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Read address and start-delay counter; the read address moves on as FETCH is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ptr  <= '0;
      in_ch   <= '0;
      dly_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (chunk_pulse) begin
            in_ptr  <= '0;
            in_ch   <= '0;
            dly_cnt <= '0;
          end
        end
        DELAY: dly_cnt <= (dly_cnt == DLY_LAST) ? '0 : dly_cnt + DLY_BITS'(1);
        FETCH: begin
          if (in_ch == CH_LAST) begin
            in_ch  <= '0;
            in_ptr <= (in_ptr == PTR_LAST) ? '0 : in_ptr + IO_BUFF_PTR_BITS'(1);
          end else begin
            in_ch  <= in_ch + CH_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sample capture: input data leaves on the FETCH exit edge, filter result on rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_din    <= '0;
      out_sample <= '0;
      out_ptr    <= '0;
      out_ch     <= '0;
    end else if (state == FETCH) begin
      out_ptr <= in_ptr;
      out_ch  <= in_ch;
      if (bypass_l) out_sample <= in_sample;
      else          flt_din    <= in_sample;
    end else if ((state == WAIT_RDY) && flt_rdy) begin
      out_sample <= sat_scale(flt_dout);
    end
  end

  // Status: bypass latched per chunk, done after the last write, sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bypass_l <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if ((state == IDLE) && chunk_pulse) bypass_l <= bypass;
      done <= (state == WRITE) && last_wr;
      if (chunk_pulse && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multichannel_chunk_processor.sv
// Directed bench for multichannel_chunk_processor (4 samples x 2 channels,
// start delay 3). Includes a sync-read input buffer model and a streaming
// filter model with programmable rfd behaviour, latency and result.
module tb_multichannel_chunk_processor;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               chunk_pulse = 1'b0;
  logic               bypass = 1'b0;
  logic [1:0]         in_ptr;
  logic [0:0]         in_ch;
  logic signed [23:0] in_sample = '0;
  logic signed [23:0] flt_din;
  logic               flt_nd;
  logic               flt_rfd;
  logic               flt_rdy = 1'b0;
  logic signed [39:0] flt_dout = '0;
  logic [1:0]         out_ptr;
  logic [0:0]         out_ch;
  logic signed [23:0] out_sample;
  logic               out_we;
  logic               busy;
  logic               done;
  logic               overrun;

  multichannel_chunk_processor #(
    .SAMPLE_SIZE(24), .IO_BUFF_SIZE(4), .NUM_CH(2),
    .FILT_OUT_SIZE(40), .FILT_SHIFT(15), .START_DELAY(3)
  ) dut (
    .clk(clk), .rst(rst), .chunk_pulse(chunk_pulse), .bypass(bypass),
    .in_ptr(in_ptr), .in_ch(in_ch), .in_sample(in_sample),
    .flt_din(flt_din), .flt_nd(flt_nd), .flt_rfd(flt_rfd), .flt_rdy(flt_rdy), .flt_dout(flt_dout),
    .out_ptr(out_ptr), .out_ch(out_ch), .out_sample(out_sample), .out_we(out_we),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs
  int          base      = 0;
  int          rfd_mode  = 0;   // 0: rfd always 1; 1: rfd low 10 cycles after each nd
  int          lat_mode  = 0;   // 0: 4 cycles; 1: random 1..8; 2: 20 cycles
  int          dout_mode = 0;   // 0: dout = din << 15; 1: dout = forced
  logic [39:0] forced    = '0;

  // cycle counter
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sync-read input buffer: data = base + ptr*16 + ch, one cycle after address
  always @(posedge clk) in_sample <= 24'(base + 16 * int'(in_ptr) + int'(in_ch));

  // streaming filter model
  int          rfd_cnt = 10;
  int          fm_cnt  = 0;
  bit          fm_pend = 1'b0;
  logic [39:0] fm_val  = '0;
  assign flt_rfd = (rfd_mode == 0) || (rfd_cnt >= 10);

  always @(posedge clk) begin
    flt_rdy <= 1'b0;
    if (flt_nd) rfd_cnt <= 0;
    else if (rfd_cnt < 10) rfd_cnt <= rfd_cnt + 1;
    if (flt_nd) begin
      fm_pend <= 1'b1;
      fm_val  <= (dout_mode == 0) ? ({{16{flt_din[23]}}, flt_din} << 15) : forced;
      case (lat_mode)
        0:       fm_cnt <= 3;
        1:       fm_cnt <= int'($urandom_range(0, 7));
        default: fm_cnt <= 19;
      endcase
    end else if (fm_pend) begin
      if (fm_cnt == 0) begin
        flt_rdy  <= 1'b1;
        flt_dout <= fm_val;
        fm_pend  <= 1'b0;
      end else begin
        fm_cnt <= fm_cnt - 1;
      end
    end
  end

  // output monitor, sampled on the falling edge
  logic [26:0] wr_rec [256];
  int          wr_cyc [256];
  int          wr_n      = 0;
  int          done_cnt  = 0;
  int          nd_count  = 0;
  int          nd_bad    = 0;
  always @(negedge clk) begin
    if (out_we) begin
      if (wr_n < 256) begin
        wr_rec[wr_n] <= {out_ptr, out_ch, out_sample};
        wr_cyc[wr_n] <= cyc;
      end
      wr_n <= wr_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (flt_nd) begin
      nd_count <= nd_count + 1;
      if (!flt_rfd) nd_bad <= nd_bad + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_in(input int b, input int i);
    return 24'(b + (i / 2) * 16 + (i % 2));
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({in_ptr, in_ch, flt_din, flt_nd, out_ptr, out_ch, out_sample, out_we, busy, done, overrun});
  endfunction

  int pulse_cyc = 0;
  task automatic pulse();
    @(negedge clk);
    pulse_cyc   = cyc;
    chunk_pulse = 1'b1;
    @(negedge clk);
    chunk_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done seen"}, 64'(done_cnt != start), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_chunk(input string tag, input int w0, input int b,
                             input bit fixed_en, input logic [23:0] fixed);
    logic [23:0] d;
    check({tag, " write count"}, 64'(wr_n - w0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      d = fixed_en ? fixed : exp_in(b, i);
      check($sformatf("%s write%0d", tag, i), 64'(wr_rec[(w0 + i) % 256]),
            64'({2'(i / 2), 1'(i % 2), d}));
    end
  endtask

  int w0, d0, n0, b0, k;

  initial begin
    // reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", outs_vec(), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    // 1: bypass chunk, order, latency, single done, no nd
    bypass = 1'b1; base = 0;
    w0 = wr_n; d0 = done_cnt; n0 = nd_count;
    pulse();
    wait_done("t1", d0);
    check_chunk("t1", w0, 0, 1'b0, 24'd0);
    check("t1 first we latency", 64'(wr_cyc[w0 % 256] - pulse_cyc), 64'd5);
    check("t1 done pulses", 64'(done_cnt - d0), 64'd1);
    check("t1 nd count", 64'(nd_count - n0), 64'd0);
    check("t1 busy after", 64'(busy), 64'd0);

    // 2: filtered chunk, dout = din<<15, includes most negative sample; bypass flipped mid-chunk
    bypass = 1'b0; base = -8388608; rfd_mode = 0; lat_mode = 0; dout_mode = 0;
    repeat (2) @(negedge clk);
    w0 = wr_n; d0 = done_cnt; n0 = nd_count;
    pulse();
    bypass = 1'b1;
    wait_done("t2", d0);
    bypass = 1'b0;
    check_chunk("t2", w0, base, 1'b0, 24'd0);
    check("t2 nd count", 64'(nd_count - n0), 64'd8);

    // 3: saturation of positive and negative full-scale results
    dout_mode = 1; forced = 40'h7F_FFFF_FFFF;
    w0 = wr_n; d0 = done_cnt;
    pulse();
    wait_done("t3p", d0);
    check_chunk("t3 pos sat", w0, 0, 1'b1, 24'h7FFFFF);
    forced = 40'h80_0000_0000;
    w0 = wr_n; d0 = done_cnt;
    pulse();
    wait_done("t3n", d0);
    check_chunk("t3 neg sat", w0, 0, 1'b1, 24'h800000);

    // 4: slow rfd, random rdy latency, samples up to the positive limit
    dout_mode = 0; rfd_mode = 1; lat_mode = 1; base = 32'h7FFFCE;
    repeat (2) @(negedge clk);
    w0 = wr_n; d0 = done_cnt; n0 = nd_count; b0 = nd_bad;
    pulse();
    wait_done("t4", d0);
    check_chunk("t4", w0, base, 1'b0, 24'd0);
    check("t4 nd count", 64'(nd_count - n0), 64'd8);
    check("t4 nd without rfd", 64'(nd_bad - b0), 64'd0);
    check("t4 overrun clear", 64'(overrun), 64'd0);

    // 5: second chunk_pulse mid-chunk
    rfd_mode = 0; lat_mode = 0; bypass = 1'b1; base = 32'h55;
    repeat (2) @(negedge clk);
    w0 = wr_n; d0 = done_cnt;
    pulse();
    repeat (6) @(negedge clk);
    chunk_pulse = 1'b1;
    @(negedge clk);
    chunk_pulse = 1'b0;
    check("t5 overrun set", 64'(overrun), 64'd1);
    wait_done("t5", d0);
    repeat (20) @(negedge clk);
    check_chunk("t5", w0, base, 1'b0, 24'd0);
    check("t5 done pulses", 64'(done_cnt - d0), 64'd1);
    check("t5 busy after", 64'(busy), 64'd0);
    check("t5 overrun sticky", 64'(overrun), 64'd1);

    // 6: asynchronous reset while waiting for rdy, then clean restart
    bypass = 1'b0; lat_mode = 2; base = 32'h123;
    repeat (2) @(negedge clk);
    w0 = wr_n; n0 = nd_count;
    pulse();
    k = 0;
    while (nd_count < n0 + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t6 second nd seen", 64'(nd_count >= n0 + 2), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6 async clear", outs_vec(), 64'd0);
    check("t6 writes before abort", 64'(wr_n - w0), 64'd1);
    repeat (30) @(negedge clk);
    check("t6 no writes in reset", 64'(wr_n - w0), 64'd1);
    check("t6 no nd in reset", 64'(nd_count - n0), 64'd2);
    rst = 1'b1;
    lat_mode = 0;
    repeat (2) @(negedge clk);
    w0 = wr_n; d0 = done_cnt;
    pulse();
    wait_done("t6", d0);
    check_chunk("t6 restart", w0, base, 1'b0, 24'd0);
    check("t6 overrun cleared", 64'(overrun), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
